// File: rtl/uart_pattern_cmd_if.sv
// Signal bundle between the UART byte stream, the pattern command parser
// and the test-pattern generator.
interface uart_pattern_cmd_if;
    logic [7:0] i_rx_byte;
    logic       i_rx_dv;
    logic       i_tx_done;
    logic [7:0] o_tx_byte;
    logic       o_tx_dv;
    logic [3:0] o_pattern;
    logic       o_pattern_valid;

    modport master (
        input  i_rx_byte,
        input  i_rx_dv,
        input  i_tx_done,
        output o_tx_byte,
        output o_tx_dv,
        output o_pattern,
        output o_pattern_valid
    );

    modport slave (
        output i_rx_byte,
        output i_rx_dv,
        output i_tx_done,
        input  o_tx_byte,
        input  o_tx_dv,
        input  o_pattern,
        input  o_pattern_valid
    );
endinterface

// File: rtl/uart_pattern_cmd.sv
// Parses "P<hex><CR>" from UART RX, sets the test pattern, answers ACK/NAK.
// UART_PATTERN_CMD_BARE_DIGIT_EN: a lone hex digit in IDLE is a full command.
module uart_pattern_cmd #(
    parameter int unsigned TIMEOUT_CLKS = 2500000,
    parameter int unsigned MAX_PATTERN  = 7,
    parameter logic [7:0]  ACK_BYTE     = 8'h4B,
    parameter logic [7:0]  NAK_BYTE     = 8'h45
) (
    input logic                clk,
    input logic                rst,
    uart_pattern_cmd_if.master bus
);
    localparam int CW =
        (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CLKS - 1);
    localparam logic [4:0] MAX_P =
        5'((MAX_PATTERN > 15) ? 15 : MAX_PATTERN);

`ifdef UART_PATTERN_CMD_BARE_DIGIT_EN
    localparam bit BARE_DIGIT = 1'b1;
`else
    localparam bit BARE_DIGIT = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        GOT_P,
        GOT_DIGIT,
        RESPOND,
        WAIT_TX
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    digit;
    logic          ack;
    logic [7:0]    tx_byte;
    logic          tx_dv;
    logic [3:0]    pattern;
    logic          pattern_valid;

    logic [7:0] rx;
    logic       is_p;
    logic       is_cr;
    logic       is_hex;
    logic [3:0] hex_val;
    logic       hex_ok;
    logic       digit_ok;
    logic       expired;

    assign rx = bus.i_rx_byte;

    always_comb begin
        is_p     = (rx == 8'h50) || (rx == 8'h70);
        is_cr    = (rx == 8'h0D);
        is_hex   = 1'b0;
        hex_val  = 4'h0;
        unique case (1'b1)
            (rx >= 8'h30 && rx <= 8'h39): begin
                is_hex  = 1'b1;
                hex_val = 4'(rx - 8'h30);
            end
            (rx >= 8'h41 && rx <= 8'h46): begin
                is_hex  = 1'b1;
                hex_val = 4'(rx - 8'h37);
            end
            (rx >= 8'h61 && rx <= 8'h66): begin
                is_hex  = 1'b1;
                hex_val = 4'(rx - 8'h57);
            end
            default: ;
        endcase
        hex_ok   = ({1'b0, hex_val} <= MAX_P);
        digit_ok = ({1'b0, digit} <= MAX_P);
        expired  = (cnt == CNT_LAST);
    end

    // Outputs are registered on the RESPOND exit edge, one cycle after the
    // terminating byte is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            digit         <= 4'h0;
            ack           <= 1'b0;
            tx_byte       <= 8'h00;
            tx_dv         <= 1'b0;
            pattern       <= 4'h0;
            pattern_valid <= 1'b0;
        end else begin
            tx_dv         <= 1'b0;
            pattern_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.i_rx_dv) begin
                        if (is_p) begin
                            state <= GOT_P;
                            cnt   <= '0;
                        end else if (BARE_DIGIT && is_hex) begin
                            digit <= hex_val;
                            ack   <= hex_ok;
                            state <= RESPOND;
                        end
                    end
                end
                GOT_P: begin
                    if (bus.i_rx_dv) begin
                        cnt <= '0;
                        if (is_hex) begin
                            digit <= hex_val;
                            state <= GOT_DIGIT;
                        end else begin
                            ack   <= 1'b0;
                            state <= RESPOND;
                        end
                    end else if (expired) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GOT_DIGIT: begin
                    if (bus.i_rx_dv) begin
                        cnt   <= '0;
                        ack   <= is_cr && digit_ok;
                        state <= RESPOND;
                    end else if (expired) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESPOND: begin
                    tx_dv   <= 1'b1;
                    tx_byte <= ack ? ACK_BYTE : NAK_BYTE;
                    if (ack) begin
                        pattern       <= digit;
                        pattern_valid <= 1'b1;
                    end
                    cnt   <= '0;
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    // A lost TX done must not wedge the parser.
                    if (bus.i_tx_done || expired) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_tx_byte       = tx_byte;
    assign bus.o_tx_dv         = tx_dv;
    assign bus.o_pattern       = pattern;
    assign bus.o_pattern_valid = pattern_valid;
endmodule

// File: tb/tb_uart_pattern_cmd.sv
// Bench for uart_pattern_cmd: two instances (MAX_PATTERN 7 and 15) share
// one byte stream; expected responses are queued and checked on output.
module tb_uart_pattern_cmd;
    localparam logic [7:0] ACK = 8'h4B;
    localparam logic [7:0] NAK = 8'h45;
    localparam logic [7:0] CR  = 8'h0D;

    typedef struct packed {
        logic [7:0] tx;
        logic [3:0] pat;
        logic       pv;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic       tx_done;

    int tests;
    int fails;
    logic [3:0] pat7;
    logic [3:0] pat15;
    exp_t q7[$];
    exp_t q15[$];

    uart_pattern_cmd_if bus7();
    uart_pattern_cmd_if bus15();

    assign bus7.i_rx_byte  = rx_byte;
    assign bus7.i_rx_dv    = rx_dv;
    assign bus7.i_tx_done  = tx_done;
    assign bus15.i_rx_byte = rx_byte;
    assign bus15.i_rx_dv   = rx_dv;
    assign bus15.i_tx_done = tx_done;

    uart_pattern_cmd #(
        .TIMEOUT_CLKS(16),
        .MAX_PATTERN (7),
        .ACK_BYTE    (ACK),
        .NAK_BYTE    (NAK)
    ) dut7 (
        .clk(clk),
        .rst(rst),
        .bus(bus7)
    );

    uart_pattern_cmd #(
        .TIMEOUT_CLKS(16),
        .MAX_PATTERN (15),
        .ACK_BYTE    (ACK),
        .NAK_BYTE    (NAK)
    ) dut15 (
        .clk(clk),
        .rst(rst),
        .bus(bus15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte is sampled at the posedge following the call.
    task automatic send(input logic [7:0] b);
        rx_byte = b;
        rx_dv   = 1'b1;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic expect_resp(input bit ok7, input bit ok15,
                               input logic [3:0] d);
        exp_t e;
        if (ok7) pat7 = d;
        if (ok15) pat15 = d;
        e.tx  = ok7 ? ACK : NAK;
        e.pat = pat7;
        e.pv  = ok7;
        q7.push_back(e);
        e.tx  = ok15 ? ACK : NAK;
        e.pat = pat15;
        e.pv  = ok15;
        q15.push_back(e);
    endtask

    task automatic check_resp(input string name, input bit give_done);
        int n;
        exp_t e7;
        exp_t e15;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus7.o_tx_dv !== 1'b1 && n < 8);
        tests++;
        if (bus7.o_tx_dv !== 1'b1) begin
            fails++;
            $display("FAIL %s: no tx strobe, got dv=%b want 1", name,
                     bus7.o_tx_dv);
            if (q7.size() > 0) void'(q7.pop_front());
            if (q15.size() > 0) void'(q15.pop_front());
            return;
        end
        tests++;
        if (n != 1) begin
            fails++;
            $display("FAIL %s latency: got %0d want 1 cycles", name, n);
        end
        e7  = q7.pop_front();
        e15 = q15.pop_front();
        tests++;
        if ({bus7.o_tx_byte, bus7.o_pattern, bus7.o_pattern_valid}
            !== e7) begin
            fails++;
            $display("FAIL %s max7: got tx=%h pat=%0d pv=%b want tx=%h pat=%0d pv=%b",
                     name, bus7.o_tx_byte, bus7.o_pattern,
                     bus7.o_pattern_valid, e7.tx, e7.pat, e7.pv);
        end
        tests++;
        if ({bus15.o_tx_dv, bus15.o_tx_byte, bus15.o_pattern,
             bus15.o_pattern_valid} !== {1'b1, e15}) begin
            fails++;
            $display("FAIL %s max15: got dv=%b tx=%h pat=%0d pv=%b want dv=1 tx=%h pat=%0d pv=%b",
                     name, bus15.o_tx_dv, bus15.o_tx_byte,
                     bus15.o_pattern, bus15.o_pattern_valid,
                     e15.tx, e15.pat, e15.pv);
        end
        @(negedge clk);
        tests++;
        if ({bus7.o_tx_dv, bus7.o_pattern_valid,
             bus15.o_tx_dv, bus15.o_pattern_valid} !== 4'b0000) begin
            fails++;
            $display("FAIL %s pulse width: got %b%b%b%b want 0000", name,
                     bus7.o_tx_dv, bus7.o_pattern_valid,
                     bus15.o_tx_dv, bus15.o_pattern_valid);
        end
        if (give_done) begin
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
    endtask

    task automatic check_silent(input string name, input int cycles);
        int hits;
        hits = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus7.o_tx_dv || bus7.o_pattern_valid ||
                bus15.o_tx_dv || bus15.o_pattern_valid) hits++;
        end
        tests++;
        if (hits != 0 || bus7.o_pattern !== pat7 ||
            bus15.o_pattern !== pat15) begin
            fails++;
            $display("FAIL %s: got strobes=%0d pat=%0d/%0d want strobes=0 pat=%0d/%0d",
                     name, hits, bus7.o_pattern, bus15.o_pattern,
                     pat7, pat15);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        tests++;
        if ({bus7.o_tx_byte, bus7.o_tx_dv, bus7.o_pattern,
             bus7.o_pattern_valid} !== 14'h0 ||
            {bus15.o_tx_byte, bus15.o_tx_dv, bus15.o_pattern,
             bus15.o_pattern_valid} !== 14'h0) begin
            fails++;
            $display("FAIL %s: got tx=%h dv=%b pat=%0d pv=%b want all zero",
                     name, bus7.o_tx_byte, bus7.o_tx_dv,
                     bus7.o_pattern, bus7.o_pattern_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pat7  = 4'h0;
        pat15 = 4'h0;
        check_reset_outputs("reset");
        check_silent("reset idle", 4);
    endtask

    task automatic test_ack();
        expect_resp(1'b1, 1'b1, 4'd3);
        send(8'h50);
        send(8'h33);
        send(CR);
        check_resp("P3 ack", 1'b1);
        send(8'h0A);
        send(CR);
        check_silent("idle lf cr", 4);
    endtask

    task automatic test_range();
        expect_resp(1'b0, 1'b1, 4'd9);
        send(8'h70);
        send(8'h39);
        send(CR);
        check_resp("p9 range", 1'b1);
    endtask

    task automatic test_bad_bytes();
        expect_resp(1'b0, 1'b0, 4'd0);
        send(8'h50);
        send(8'h47);
        check_resp("PG nak", 1'b1);
        expect_resp(1'b0, 1'b0, 4'd0);
        send(8'h50);
        send(8'h31);
        send(8'h58);
        check_resp("P1X nak", 1'b1);
        expect_resp(1'b0, 1'b1, 4'd10);
        send(8'h50);
        send(8'h61);
        send(CR);
        check_resp("Pa hex", 1'b1);
    endtask

    task automatic test_timeout();
        send(8'h50);
        repeat (20) @(negedge clk);
`ifdef UART_PATTERN_CMD_BARE_DIGIT_EN
        expect_resp(1'b1, 1'b1, 4'd2);
        send(8'h32);
        check_resp("timeout bare 2", 1'b1);
        send(CR);
`else
        send(8'h32);
        send(CR);
`endif
        check_silent("timeout abort", 6);
        // Digit lands on the expiry cycle and must still be taken.
        expect_resp(1'b1, 1'b1, 4'd2);
        send(8'h50);
        repeat (15) @(negedge clk);
        send(8'h32);
        send(CR);
        check_resp("expiry edge", 1'b1);
    endtask

    task automatic test_wait_tx();
        expect_resp(1'b1, 1'b1, 4'd5);
        send(8'h50);
        send(8'h35);
        send(CR);
        check_resp("P5 no done", 1'b0);
        send(8'h50);
        send(8'h31);
        send(CR);
        check_silent("wait_tx drop", 22);
        expect_resp(1'b1, 1'b1, 4'd6);
        send(8'h50);
        send(8'h36);
        send(CR);
        check_resp("after tx timeout", 1'b1);
    endtask

    task automatic test_back_to_back();
        expect_resp(1'b1, 1'b1, 4'd1);
        send(8'h50);
        send(8'h31);
        send(CR);
        check_resp("b2b first", 1'b1);
        expect_resp(1'b1, 1'b1, 4'd4);
        send(8'h70);
        send(8'h34);
        send(CR);
        check_resp("b2b second", 1'b1);
    endtask

    task automatic test_bare_digit();
`ifdef UART_PATTERN_CMD_BARE_DIGIT_EN
        expect_resp(1'b1, 1'b1, 4'd5);
        send(8'h35);
        check_resp("bare 5", 1'b1);
`else
        send(8'h35);
        check_silent("bare 5 ignored", 6);
`endif
    endtask

    task automatic test_reset_mid();
        send(8'h50);
        send(8'h34);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pat7  = 4'h0;
        pat15 = 4'h0;
        check_reset_outputs("reset mid");
        send(CR);
        check_silent("reset mid cr", 6);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        rx_byte = 8'h00;
        rx_dv   = 1'b0;
        tx_done = 1'b0;
        pat7    = 4'h0;
        pat15   = 4'h0;
        @(negedge clk);
        test_reset();
        test_ack();
        test_range();
        test_bad_bytes();
        test_timeout();
        test_wait_tx();
        test_back_to_back();
        test_bare_digit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
